lut_prog_loader: RTL and testbench
==================================

LUT_PROG_LOADER -- requirements
Module: lut_prog_loader

Interface
REQ-001 SHALL have parameter G_ADDR_WIDTH, default 10, meaning the LUT holds N = 2**G_ADDR_WIDTH entries to program.
REQ-002 SHALL have parameter G_DWIDTH, default 24, meaning the LUT entry width; legal range 1..32.
REQ-003 SHALL have parameter G_FIFO_DEPTH, default 16, meaning the buffer depth in words; must be a power of two, minimum 2.
REQ-004 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  synchronous enable; 0 forces IDLE and flushes the FIFO.
REQ-007 SHALL have port start  in  1  single-cycle request to begin a programming pass.
REQ-008 SHALL have ports wr_data  in  32, wr_valid  in  1, wr_ready  out  1, forming the host word stream.
REQ-009 SHALL have ports lut_prog_din  out  G_DWIDTH, lut_prog_din_valid  out  1, lut_prog_din_ready  in  1, forming the LUT programming stream.
REQ-010 SHALL have port lut_prog_din_done  in  1, the LUT's report that programming is complete.
REQ-011 SHALL have ports busy  out  1, done  out  1, overflow_err  out  1 (sticky), word_count  out  G_ADDR_WIDTH+1 (words delivered to the LUT).

Function
REQ-012 SHALL implement four states: IDLE, LOAD, WAIT_DONE and DONE.
REQ-013 IDLE SHALL go to LOAD on start=1, and in the same cycle clear word_count, the accepted-word counter, the FIFO and overflow_err.
REQ-014 DONE SHALL behave as IDLE on start=1; start SHALL be ignored in LOAD and WAIT_DONE.
REQ-015 LOAD SHALL go to WAIT_DONE on the cycle in which the Nth LUT handshake (lut_prog_din_valid and lut_prog_din_ready both 1) occurs.
REQ-016 WAIT_DONE SHALL go to DONE on the first cycle with lut_prog_din_done=1; WAIT_DONE has no timeout.
REQ-017 The FIFO SHALL be first-word-fall-through with G_FIFO_DEPTH entries and SHALL store wr_data[G_DWIDTH-1:0]; upper bits are discarded and no sign extension is applied.
REQ-018 In LOAD, wr_ready SHALL be 1 when (FIFO not full and accepted < N) or accepted = N; a host handshake with accepted < N SHALL push the word and increment accepted.
REQ-019 A host handshake in LOAD with accepted = N, or any handshake in WAIT_DONE or DONE, SHALL be discarded and SHALL set overflow_err.
REQ-020 wr_ready SHALL be 1 in WAIT_DONE and DONE (sink mode) and 0 in IDLE.
REQ-021 lut_prog_din_valid SHALL be 1 only in LOAD with the FIFO non-empty; lut_prog_din SHALL equal the FIFO head and stay stable while valid=1 and ready=0.
REQ-022 Latency from a host handshake into an empty FIFO to lut_prog_din_valid=1 SHALL be exactly 1 cycle.
REQ-023 A push and a pop in the same cycle SHALL both occur; a full FIFO SHALL NOT accept a push even when a pop happens in that cycle (no pass-through).
REQ-024 word_count SHALL increment on each LUT handshake, saturate at N, and hold its value in DONE.
REQ-025 busy SHALL be 1 in LOAD and WAIT_DONE; done SHALL be 1 only in DONE.
REQ-026 enable=0 SHALL force IDLE, flush the FIFO and deassert all valid/ready outputs on the next edge; counters and overflow_err SHALL hold.

Reset
REQ-027 While reset=1, SHALL immediately force state=IDLE, FIFO empty, word_count=0, accepted=0, and all of wr_ready, lut_prog_din_valid, busy, done and overflow_err = 0.
REQ-028 A reset mid-pass SHALL discard buffered words; a new pass SHALL require a new start.
REQ-029 lut_prog_din SHALL reset to 0.

Verification (G_ADDR_WIDTH=2 so N=4, G_FIFO_DEPTH=2)
REQ-030 Basic pass: start, write 0x11,0x22,0x33,0x44 with ready tied 1, then done pulse -> LUT receives 0x11..0x44 in order; word_count=4; done=1; overflow_err=0.
REQ-031 Backpressure: lut_prog_din_ready=0 while 3 words are offered -> wr_ready drops after 2 words; the head (0x11) is held stable; releasing ready delivers all 4 words with none lost.
REQ-032 Overflow: write 5 words in LOAD -> 5th word accepted but not forwarded; overflow_err=1; word_count=4.
REQ-033 Truncation: wr_data=0xFFABCDEF with G_DWIDTH=24 -> lut_prog_din=0xABCDEF.
REQ-034 Reset mid-pass: async reset after 2 words -> all outputs 0 immediately; a new start then 4 words completes normally.
REQ-035 Restart: start in DONE -> word_count=0 and overflow_err=0 next cycle; start while busy=1 -> ignored.

Source files
------------

// File: rtl/lut_prog_loader.sv
// Streams exactly 2**G_ADDR_WIDTH host words through a first-word-fall-through
// FIFO into a LUT programming port, then waits for the LUT to report completion.
module lut_prog_loader #(
  parameter int unsigned G_ADDR_WIDTH = 10,
  parameter int unsigned G_DWIDTH     = 24,
  parameter int unsigned G_FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [G_DWIDTH-1:0]   lut_prog_din,
  output logic                  lut_prog_din_valid,
  input  logic                  lut_prog_din_ready,
  input  logic                  lut_prog_din_done,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
  output logic [G_ADDR_WIDTH:0] word_count
);

  localparam int unsigned PW = $clog2(G_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = G_ADDR_WIDTH + 1;
  localparam logic [NW-1:0] NUM_WORDS = {1'b1, {G_ADDR_WIDTH{1'b0}}};
  localparam logic [NW-1:0] LAST_WORD = NUM_WORDS - NW'(1);
  localparam logic [CW-1:0] DEPTH     = CW'(G_FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_DONE, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [G_DWIDTH-1:0] mem_q [G_FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d, pop_left;
  logic [NW-1:0]       acc_q, acc_d, wcnt_q, wcnt_d;
  logic                ovf_q, ovf_d;
  logic [G_DWIDTH-1:0] head_q, head_d;
  logic                wr_ready_q, wr_ready_d, valid_q, valid_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                host_hs, lut_hs, push, pop, clear, begin_pass;
  logic [G_DWIDTH-1:0] wr_word;
  logic                unused_wr_data;

  // Upper host bits are intentionally dropped; the reduction only marks them as seen.
  assign wr_word        = wr_data[G_DWIDTH-1:0];
  assign unused_wr_data = ^wr_data;

  assign host_hs = wr_valid & wr_ready_q;
  assign lut_hs  = valid_q & lut_prog_din_ready;

  // Next-state, FIFO bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    ovf_d      = ovf_q;
    head_d     = head_q;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    begin_pass = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          begin_pass = start;
        end
        ST_LOAD: begin
          if (host_hs) begin
            if (acc_q != NUM_WORDS) begin
              push  = 1'b1;
              acc_d = acc_q + NW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (lut_hs) begin
            pop = 1'b1;
            if (wcnt_q != NUM_WORDS) wcnt_d = wcnt_q + NW'(1);
            if (wcnt_q == LAST_WORD) state_d = ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (host_hs) ovf_d = 1'b1;
          if (lut_prog_din_done) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (host_hs) ovf_d = 1'b1;
          begin_pass = start;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A new pass wipes the previous pass's bookkeeping, including a sink-mode overflow.
    if (begin_pass) begin
      state_d = ST_LOAD;
      clear   = 1'b1;
      acc_d   = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
    end

    pop_left = cnt_q - CW'(pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = pop_left + CW'(push);
    end

    // Head register tracks the word that will be at the front after this edge.
    if (cnt_d != '0) begin
      head_d = (push && (pop_left == '0)) ? wr_word : mem_q[rd_ptr_d];
    end

    wr_ready_d = 1'b0;
    case (state_d)
      ST_LOAD:               wr_ready_d = (acc_d == NUM_WORDS) || (cnt_d != DEPTH);
      ST_WAIT_DONE, ST_DONE: wr_ready_d = 1'b1;
      default:               wr_ready_d = 1'b0;
    endcase
    valid_d = (state_d == ST_LOAD) && (cnt_d != '0);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_WAIT_DONE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      head_q     <= '0;
      wr_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      head_q     <= head_d;
      wr_ready_q <= wr_ready_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_word;
  end

  assign wr_ready           = wr_ready_q;
  assign lut_prog_din       = head_q;
  assign lut_prog_din_valid = valid_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign overflow_err       = ovf_q;
  assign word_count         = wcnt_q;

endmodule

// File: tb/tb_lut_prog_loader.sv
// Self-checking bench for lut_prog_loader (N=4, FIFO depth 2): hand-derived vector
// table, directed corner sequences and random traffic against a queue-based model.
module tb_lut_prog_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 24;
  localparam int unsigned FD = 2;
  localparam int          N  = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          start;
  logic [31:0]   wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] lut_prog_din;
  logic          lut_prog_din_valid;
  logic          lut_prog_din_ready;
  logic          lut_prog_din_done;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic [AW:0]   word_count;

  lut_prog_loader #(.G_ADDR_WIDTH(AW), .G_DWIDTH(DW), .G_FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .lut_prog_din(lut_prog_din), .lut_prog_din_valid(lut_prog_din_valid),
    .lut_prog_din_ready(lut_prog_din_ready), .lut_prog_din_done(lut_prog_din_done),
    .busy(busy), .done(done), .overflow_err(overflow_err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: phase 0=idle 1=load 2=wait_done 3=done, buffered words in a queue.
  int            phase = 0;
  logic [DW-1:0] mq[$];
  int            acc = 0;
  int            wc  = 0;
  bit            movf = 1'b0;
  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_log[$];

  function automatic bit e_wrr();
    if (phase == 1) return ((mq.size() < FD) && (acc < N)) || (acc == N);
    return (phase == 2) || (phase == 3);
  endfunction

  function automatic bit e_vld();
    return (phase == 1) && (mq.size() > 0);
  endfunction

  task automatic m_reset();
    phase = 0;
    mq.delete();
    acc  = 0;
    wc   = 0;
    movf = 1'b0;
  endtask

  task automatic m_begin();
    phase = 1;
    mq.delete();
    acc  = 0;
    wc   = 0;
    movf = 1'b0;
  endtask

  task automatic m_step();
    bit hw;
    bit hr;
    logic [DW-1:0] tmp;
    hw = wr_valid && e_wrr();
    hr = e_vld() && lut_prog_din_ready;
    if (!enable) begin
      phase = 0;
      mq.delete();
    end else begin
      case (phase)
        0: if (start) m_begin();
        1: begin
          if (hr) begin
            tmp = mq.pop_front();
            if (wc < N) wc++;
            if (wc == N) phase = 2;
          end
          if (hw) begin
            if (acc < N) begin
              mq.push_back(wr_data[DW-1:0]);
              acc++;
            end else begin
              movf = 1'b1;
            end
          end
        end
        2: begin
          if (hw) movf = 1'b1;
          if (lut_prog_din_done) phase = 3;
        end
        default: begin
          if (hw) movf = 1'b1;
          if (start) m_begin();
        end
      endcase
    end
  endtask

  task automatic m_check();
    chk("m_wr_ready", 32'(wr_ready), 32'(e_wrr()));
    chk("m_valid", 32'(lut_prog_din_valid), 32'(e_vld()));
    chk("m_busy", 32'(busy), 32'((phase == 1) || (phase == 2)));
    chk("m_done", 32'(done), 32'(phase == 3));
    chk("m_overflow", 32'(overflow_err), 32'(movf));
    chk("m_word_count", 32'(word_count), 32'(wc));
    if (e_vld()) chk("m_lut_din", 32'(lut_prog_din), 32'(mq[0]));
  endtask

  task automatic drive(input logic en, input logic st, input logic wv,
                       input logic [31:0] wd, input logic rdy, input logic dn);
    enable             = en;
    start              = st;
    wr_valid           = wv;
    wr_data            = wd;
    lut_prog_din_ready = rdy;
    lut_prog_din_done  = dn;
  endtask

  // One clock: log the LUT handshake, advance the model, then compare after the edge.
  task automatic cycle();
    if (lut_prog_din_valid && lut_prog_din_ready) got.push_back(lut_prog_din);
    m_step();
    @(posedge clk);
    #1;
    m_check();
  endtask

  task automatic chk_log(input string name);
    logic [DW-1:0] g;
    chk({name, "_count"}, 32'(got.size()), 32'(exp_log.size()));
    for (int k = 0; k < exp_log.size(); k++) begin
      g = (k < got.size()) ? got[k] : 'x;
      chk($sformatf("%s_word%0d", name, k), 32'(g), 32'(exp_log[k]));
    end
  endtask

  typedef struct {
    logic        st;
    logic        wv;
    logic [31:0] wd;
    logic        dn;
    logic        e_wrr;
    logic        e_vld;
    logic [23:0] e_din;
    logic        e_bsy;
    logic        e_dne;
    logic        e_ovf;
    logic [2:0]  e_wc;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic wv, input logic [31:0] wd,
                               input logic dn, input logic wrr, input logic vld,
                               input logic [23:0] din, input logic bsy, input logic dne,
                               input logic ovf, input int wcnt);
    vec_t v;
    v.st = st; v.wv = wv; v.wd = wd; v.dn = dn;
    v.e_wrr = wrr; v.e_vld = vld; v.e_din = din;
    v.e_bsy = bsy; v.e_dne = dne; v.e_ovf = ovf; v.e_wc = 3'(wcnt);
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    //            st    wv    data           dn    wrr   vld   din          bsy   dne   ovf   wc
    tbl[0]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 0);
    tbl[1]  = mkv(1'b0, 1'b1, 32'h11,       1'b0, 1'b1, 1'b1, 24'h11,     1'b1, 1'b0, 1'b0, 0);
    tbl[2]  = mkv(1'b0, 1'b1, 32'h22,       1'b0, 1'b1, 1'b1, 24'h22,     1'b1, 1'b0, 1'b0, 1);
    tbl[3]  = mkv(1'b0, 1'b1, 32'h33,       1'b0, 1'b1, 1'b1, 24'h33,     1'b1, 1'b0, 1'b0, 2);
    tbl[4]  = mkv(1'b0, 1'b1, 32'h44,       1'b0, 1'b1, 1'b1, 24'h44,     1'b1, 1'b0, 1'b0, 3);
    tbl[5]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 4);
    tbl[6]  = mkv(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 4);
    tbl[7]  = mkv(1'b0, 1'b1, 32'h99,       1'b0, 1'b1, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 4);
    tbl[8]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 0);
    tbl[9]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 0);
    tbl[10] = mkv(1'b0, 1'b1, 32'hFFABCDEF, 1'b0, 1'b1, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 0);
    tbl[11] = mkv(1'b0, 1'b1, 32'h12,       1'b0, 1'b1, 1'b1, 24'h12,     1'b1, 1'b0, 1'b0, 1);
    tbl[12] = mkv(1'b0, 1'b1, 32'h13,       1'b0, 1'b1, 1'b1, 24'h13,     1'b1, 1'b0, 1'b0, 2);
    tbl[13] = mkv(1'b0, 1'b1, 32'h14,       1'b0, 1'b1, 1'b1, 24'h14,     1'b1, 1'b0, 1'b0, 3);
    tbl[14] = mkv(1'b0, 1'b1, 32'h15,       1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 4);
    tbl[15] = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 4);
    tbl[16] = mkv(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 4);

    // Reset state while reset is held.
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_valid", 32'(lut_prog_din_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_overflow", 32'(overflow_err), 32'h0);
    chk("rst_word_count", 32'(word_count), 32'h0);
    chk("rst_lut_din", 32'(lut_prog_din), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    m_check();

    // Basic pass, sink-mode overflow, restart, truncation, LOAD overflow, start ignored while busy.
    got.delete();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, tbl[i].st, tbl[i].wv, tbl[i].wd, 1'b1, tbl[i].dn);
      cycle();
      chk($sformatf("t%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wrr));
      chk($sformatf("t%0d_valid", i), 32'(lut_prog_din_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("t%0d_lut_din", i), 32'(lut_prog_din), 32'(tbl[i].e_din));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].e_bsy));
      chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].e_dne));
      chk($sformatf("t%0d_overflow", i), 32'(overflow_err), 32'(tbl[i].e_ovf));
      chk($sformatf("t%0d_word_count", i), 32'(word_count), 32'(tbl[i].e_wc));
    end
    exp_log = '{24'h11, 24'h22, 24'h33, 24'h44, 24'hABCDEF, 24'h12, 24'h13, 24'h14};
    chk_log("table_lut_log");

    // Backpressure: FIFO fills after two words, head held, then drains without loss.
    got.delete();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0); cycle();
    chk("bp_wr_ready_full", 32'(wr_ready), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0); cycle();
    chk("bp_head_stable0", 32'(lut_prog_din), 32'h11);
    cycle();
    chk("bp_head_stable1", 32'(lut_prog_din), 32'h11);
    chk("bp_wr_ready_held", 32'(wr_ready), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 1'b0); cycle();
    cycle();
    drive(1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); cycle();
    chk("bp_done", 32'(done), 32'h1);
    chk("bp_word_count", 32'(word_count), 32'h4);
    chk("bp_overflow", 32'(overflow_err), 32'h0);
    exp_log = '{24'h11, 24'h22, 24'h33, 24'h44};
    chk_log("bp_lut_log");

    // Asynchronous reset mid-pass with words still buffered.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("mid_rst_valid", 32'(lut_prog_din_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_overflow", 32'(overflow_err), 32'h0);
    chk("mid_rst_word_count", 32'(word_count), 32'h0);
    chk("mid_rst_lut_din", 32'(lut_prog_din), 32'h0);
    #2;
    reset = 1'b0;
    m_reset();
    cycle();
    got.delete();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hB1 + 32'(k), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); cycle();
    chk("post_rst_done", 32'(done), 32'h1);
    chk("post_rst_word_count", 32'(word_count), 32'h4);
    exp_log = '{24'hB1, 24'hB2, 24'hB3, 24'hB4};
    chk_log("post_rst_lut_log");

    // Random traffic, including enable drops, against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 31) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
